// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS main control unit.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives every datapath mux and enable as a decode of the current state.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   op[5:0]              opcode from IR[31:26]
//   mem_ready            memory finished the current read/write this cycle
//   PCWrite, PCWriteCond unconditional / zero-qualified PC load
//   IorD                 memory address source (0=PC, 1=ALUOut)
//   MemRead, MemWrite    memory requests
//   MemtoReg             register write data (0=ALUOut, 1=MDR)
//   IRWrite              instruction register load
//   PCSource[1:0]        00=ALU, 01=ALUOut, 10=jump target
//   ALUOp[1:0]           00=add, 01=sub, 10=funct
//   ALUSrcA, ALUSrcB[1:0] ALU operand selects
//   RegWrite, RegDst     register file write enable / destination select
//   state[3:0]           current state code
//   instr_done           pulse in the final cycle of each instruction
//   illegal_op           pulse when DECODE sees an unsupported opcode
module mc_control_fsm #(
    parameter logic [5:0] R_FORMAT = 6'd0,
    parameter logic [5:0] LW       = 6'd35,
    parameter logic [5:0] SW       = 6'd43,
    parameter logic [5:0] BEQ      = 6'd4,
    parameter logic [5:0] J        = 6'd2,
    parameter logic [5:0] ADDI     = 6'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    state_t cur, nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cur <= FETCH;
        else        cur <= nxt;

    assign state = cur;

    // Outputs are gated by rst_n so they drop in the same cycle reset asserts,
    // not only after the state register has been cleared.
    always_comb begin
        nxt         = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        if (rst_n) begin
            case (cur)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    nxt     = mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (op)
                        LW, SW:   nxt = MEM_ADDR;
                        R_FORMAT: nxt = EXECUTE;
                        BEQ:      nxt = BRANCH;
                        J:        nxt = JUMP;
                        ADDI:     nxt = ADDI_EXEC;
                        default: begin
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    nxt     = (op == LW) ? MEM_READ : MEM_WRITE;
                end
                MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    nxt     = mem_ready ? MEM_WB : MEM_READ;
                end
                MEM_WB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WRITE: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                    nxt        = mem_ready ? FETCH : MEM_WRITE;
                end
                EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                    nxt     = R_WB;
                end
                R_WB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                end
                JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
                ADDI_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    nxt     = ADDI_WB;
                end
                ADDI_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: nxt = FETCH;
            endcase
        end
    end
endmodule
